// File: rtl/dcache_responder_pkg.sv
// Shared types, default geometry and address-split helpers for the data cache.
package dcache_pkg;

    localparam int DC_LINES      = 64;
    localparam int DC_N_BITS     = 32;
    localparam int DC_INDEX_BITS = $clog2(DC_LINES);
    localparam int DC_TAG_BITS   = DC_N_BITS - DC_INDEX_BITS - 2;

    // Controller states: idle/lookup, waiting on a memory read, waiting on a memory write.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } dc_state_t;

    // Line index of a byte address (byte offset bits are dropped).
    function automatic logic [DC_INDEX_BITS-1:0] get_index(input logic [DC_N_BITS-1:0] addr);
        return addr[DC_INDEX_BITS+1:2];
    endfunction

    // Tag field of a byte address.
    function automatic logic [DC_TAG_BITS-1:0] get_tag(input logic [DC_N_BITS-1:0] addr);
        return addr[DC_N_BITS-1:DC_INDEX_BITS+2];
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// Core-side load/store bus plus main-memory req/ready bus of the data cache.
interface dcache_responder_if #(
    parameter int N_Bits = 32
);
    logic              MemRead;
    logic              MemWrite;
    logic [N_Bits-1:0] Addr;
    logic [N_Bits-1:0] WriteData;
    logic [N_Bits-1:0] ReadData;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [N_Bits-1:0] mem_addr;
    logic [N_Bits-1:0] mem_wdata;
    logic [N_Bits-1:0] mem_rdata;
    logic              mem_ready;

    // The cache's view of the bus.
    modport slave (
        input  MemRead, MemWrite, Addr, WriteData, mem_rdata, mem_ready,
        output ReadData, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    // The core/memory side driving the cache.
    modport master (
        output MemRead, MemWrite, Addr, WriteData, mem_rdata, mem_ready,
        input  ReadData, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_responder_array.sv
// Tag/data/valid storage: asynchronous read by index, one synchronous fill/update port.
// Only the valid bits are reset; tag and data contents are don't-care while invalid.
module dcache_array #(
    parameter int LINES     = 64,
    parameter int TAG_BITS  = 24,
    parameter int DATA_BITS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(LINES)-1:0] rd_idx_i,
    output logic                     rd_valid_o,
    output logic [TAG_BITS-1:0]      rd_tag_o,
    output logic [DATA_BITS-1:0]     rd_data_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(LINES)-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]      wr_tag_i,
    input  logic [DATA_BITS-1:0]     wr_data_i
);
    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    // Valid bits: cleared asynchronously on reset, set on every fill/update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage, written by the fill/update port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for a single-cycle core.
// Read hits return in the same cycle; misses and all stores stall the core while a
// req/ready transaction runs against main memory.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int N_Bits = 32,
    parameter int LINES  = 64
) (
    input  logic               clk,
    input  logic               rst,
    dcache_responder_if.slave  bus
);
    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_BITS   = N_Bits - INDEX_BITS - 2;

    dc_state_t         state_q, state_d;
    logic [N_Bits-1:0] addr_q, addr_d;
    logic [N_Bits-1:0] wdata_q, wdata_d;
    logic              hit_q, hit_d;

    logic [INDEX_BITS-1:0] idx_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic [INDEX_BITS-1:0] idx_lat_s;
    logic [TAG_BITS-1:0]   tag_lat_s;
    logic                  rd_valid_s;
    logic [TAG_BITS-1:0]   rd_tag_s;
    logic [N_Bits-1:0]     rd_data_s;
    logic                  hit_s;
    logic                  wr_en_s;
    logic [N_Bits-1:0]     wr_data_s;
    logic                  unused_s;

    // Byte-offset bits are intentionally ignored: word accesses only.
    assign unused_s  = ^bus.Addr[1:0];
    assign idx_s     = bus.Addr[INDEX_BITS+1:2];
    assign tag_s     = bus.Addr[N_Bits-1:INDEX_BITS+2];
    assign idx_lat_s = addr_q[INDEX_BITS+1:2];
    assign tag_lat_s = addr_q[N_Bits-1:INDEX_BITS+2];
    // Tag compare only counts when the line is valid, so stale tags never hit.
    assign hit_s     = rd_valid_s && (rd_tag_s == tag_s);

    dcache_array #(
        .LINES     (LINES),
        .TAG_BITS  (TAG_BITS),
        .DATA_BITS (N_Bits)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (idx_s),
        .rd_valid_o (rd_valid_s),
        .rd_tag_o   (rd_tag_s),
        .rd_data_o  (rd_data_s),
        .wr_en_i    (wr_en_s),
        .wr_idx_i   (idx_lat_s),
        .wr_tag_i   (tag_lat_s),
        .wr_data_i  (wr_data_s)
    );

    // State register and request latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state, handshake outputs and array update control.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        hit_d         = hit_q;
        bus.stall     = 1'b0;
        bus.ReadData  = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        wr_en_s       = 1'b0;
        wr_data_s     = bus.mem_rdata;
        if (rst) begin
            // Everything stays quiet while reset is held, even with a request pending.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.MemWrite) begin
                        // Stores always go to memory; a simultaneous read is dropped.
                        bus.stall = 1'b1;
                        addr_d    = {bus.Addr[N_Bits-1:2], 2'b00};
                        wdata_d   = bus.WriteData;
                        hit_d     = hit_s;
                        state_d   = WR_WAIT;
                    end else if (bus.MemRead) begin
                        if (hit_s) begin
                            bus.ReadData = rd_data_s;
                        end else begin
                            bus.stall = 1'b1;
                            addr_d    = {bus.Addr[N_Bits-1:2], 2'b00};
                            state_d   = RD_WAIT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                RD_WAIT: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = addr_q;
                    if (bus.mem_ready) begin
                        // Bypass the returning word to the core and fill the line.
                        bus.ReadData = bus.mem_rdata;
                        wr_en_s      = 1'b1;
                        wr_data_s    = bus.mem_rdata;
                        state_d      = IDLE;
                    end else begin
                        bus.stall = 1'b1;
                    end
                end
                WR_WAIT: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = addr_q;
                    bus.mem_wdata = wdata_q;
                    wr_data_s     = wdata_q;
                    if (bus.mem_ready) begin
                        // Write-through: refresh the line only if the store hit.
                        wr_en_s = hit_q;
                        state_d = IDLE;
                    end else begin
                        bus.stall = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench: directed scenarios followed by random accesses, all checked
// against a line-level cache model and a word-addressed memory model.
module tb_dcache_responder;
    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    dcache_responder_if #(.N_Bits(32)) bus ();

    dcache_responder #(.N_Bits(32), .LINES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: 64 one-word lines, tag = addr / 256, index = (addr / 4) % 64.
    bit          m_valid [64];
    logic [31:0] m_tag   [64];
    logic [31:0] m_data  [64];
    logic [31:0] mem_m   [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] waddr);
        if (!mem_m.exists(waddr)) mem_m[waddr] = $urandom;
        return mem_m[waddr];
    endfunction

    // One core request, called just after a rising edge; returns just after the
    // rising edge that ends the request. lat = cycle of mem_req in which mem_ready pulses.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input bit idle_rdy);
        int          idx;
        logic [31:0] tg;
        logic [31:0] waddr;
        logic [31:0] rdv;
        bit          hit;
        idx   = int'((a / 4) % 64);
        tg    = a / 256;
        waddr = a & 32'hFFFF_FFFC;
        hit   = m_valid[idx] && (m_tag[idx] == tg);
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.Addr      = a;
        bus.WriteData = wd;
        bus.mem_ready = (!rd && !wr) ? idle_rdy : 1'b0;
        bus.mem_rdata = $urandom;
        @(negedge clk);
        if (!rd && !wr) begin
            chk("idle_stall", {31'd0, bus.stall}, 32'd0);
            chk("idle_req", {31'd0, bus.mem_req}, 32'd0);
            chk("idle_rdata", bus.ReadData, 32'd0);
        end else if (!wr && hit) begin
            chk("hit_stall", {31'd0, bus.stall}, 32'd0);
            chk("hit_req", {31'd0, bus.mem_req}, 32'd0);
            chk("hit_rdata", bus.ReadData, m_data[idx]);
        end else begin
            rdv = wr ? 32'd0 : mem_read(waddr);
            chk("miss_stall0", {31'd0, bus.stall}, 32'd1);
            chk("miss_req0", {31'd0, bus.mem_req}, 32'd0);
            chk("miss_rdata0", bus.ReadData, 32'd0);
            for (int j = 1; j <= lat; j++) begin
                @(posedge clk);
                #1;
                bus.mem_ready = (j == lat);
                bus.mem_rdata = (j == lat) ? rdv : $urandom;
                @(negedge clk);
                chk("wait_req", {31'd0, bus.mem_req}, 32'd1);
                chk("wait_we", {31'd0, bus.mem_we}, {31'd0, wr});
                chk("wait_addr", bus.mem_addr, waddr);
                if (wr) chk("wait_wdata", bus.mem_wdata, wd);
                chk("wait_stall", {31'd0, bus.stall}, (j == lat) ? 32'd0 : 32'd1);
                chk("wait_rdata", bus.ReadData, (j == lat && !wr) ? rdv : 32'd0);
            end
            if (wr) begin
                mem_m[waddr] = wd;
                if (hit) m_data[idx] = wd;
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = rdv;
            end
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        int r;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        rst           = 1'b1;
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.Addr      = 32'h0000_0010;
        bus.WriteData = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;
        mem_m[32'h0000_0010] = 32'hDEAD_BEEF;

        // Reset state: outputs quiet even though a read is presented.
        @(negedge clk);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata", bus.ReadData, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold read miss, read hit.
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 1'b0);
        // Store hit write-through, then read it back.
        access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 2, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 1'b0);
        chk("wt_model", m_data[4], 32'h1234_5678);
        // Store miss without allocation, then the read misses.
        access(1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_0200, 2, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 2, 1'b0);
        // Write wins over a simultaneous read; stray mem_ready in idle is ignored.
        access(1'b1, 1'b1, 32'h0000_0014, 32'h5555_AAAA, 1, 1'b0);
        access(1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b1);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 1'b0);

        // Reset in the middle of a read miss.
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        bus.Addr     = 32'h0000_0404;
        @(negedge clk);
        chk("mid_stall0", {31'd0, bus.stall}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_req", {31'd0, bus.mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("mid_rst_addr", bus.mem_addr, 32'd0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("mid_rst_rdata", bus.ReadData, 32'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.mem_ready = 1'b0;
        bus.MemRead   = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;

        // After reset 0x10 misses; conflict eviction on index 4.
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0110, 32'h0, 3, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 1'b0);

        // Random traffic over a small address pool to mix hits, misses and aliases.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) * 256) + ($urandom_range(0, 7) * 4) + $urandom_range(0, 3);
            if (r == 0)
                access(1'b0, 1'b0, a, 32'h0, 1, 1'($urandom_range(0, 1)));
            else if (r <= 5)
                access(1'b1, 1'b0, a, 32'h0, $urandom_range(1, 4), 1'b0);
            else if (r <= 8)
                access(1'b0, 1'b1, a, $urandom, $urandom_range(1, 4), 1'b0);
            else
                access(1'b1, 1'b1, a, $urandom, $urandom_range(1, 4), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-side responder for the single-cycle core: serves the core's load/store requests (address = ALUResult, store data = WriteData, MemWrite/MemRead) and returns ReadData.
- Direct-mapped, write-through, no-write-allocate cache with one 32-bit word per line.
- On a miss or any store it asserts `stall`, which freezes the PC, and runs a req/ready handshake with a multi-cycle main memory.
- Sits between the datapath and the main-memory model.

Parameters:
- N_Bits, 32, data and address width.
- LINES, 64, number of cache lines; must be a power of 2.
- INDEX_BITS, $clog2(LINES), index field width. This is a derived localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- MemRead  input  1  core load request, held stable while `stall`=1.
- MemWrite  input  1  core store request, held stable while `stall`=1.
- Addr  input  N_Bits  byte address from the core ALU.
- WriteData  input  N_Bits  store data from the core.
- ReadData  output  N_Bits  load data to the core.
- stall  output  1  freezes the core PC and register writeback.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  N_Bits  word-aligned memory address.
- mem_wdata  output  N_Bits  memory write data.
- mem_rdata  input  N_Bits  memory read data; valid when mem_ready=1.
- mem_ready  input  1  one-cycle completion pulse from memory.

Behaviour:
- Address split: Addr[1:0] ignored (word accesses only); index = Addr[INDEX_BITS+1:2]; tag = Addr[N_Bits-1:INDEX_BITS+2].
- State machine: IDLE, RD_WAIT, WR_WAIT.
- Reset (async): state=IDLE; all valid bits=0; latched addr/data=0. Outputs during reset: stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0. Tag/data arrays are not reset.
- IDLE, no request: stall=0, mem_req=0, ReadData=0.
- IDLE, read hit (valid[index] & tag match): ReadData = data[index] combinationally, stall=0. Zero-cycle latency; no state change.
- IDLE, read miss:
  - stall=1 combinationally.
  - Latch Addr (word-aligned) into addr_q.
  - Next state RD_WAIT.
- IDLE, MemWrite:
  - stall=1.
  - Latch Addr and WriteData.
  - Next state WR_WAIT.
  - If MemWrite and MemRead are both 1, the write takes priority and the read is ignored.
- RD_WAIT:
  - mem_req=1, mem_we=0, mem_addr=addr_q.
  - stall=1 until mem_ready.
  - In the mem_ready cycle: stall=0, ReadData=mem_rdata (bypass); at the clock edge, data[idx]=mem_rdata, tag[idx]=tag_q, valid[idx]=1; next state IDLE.
- WR_WAIT:
  - mem_req=1, mem_we=1, mem_addr=addr_q, mem_wdata=wdata_q.
  - stall=1 until mem_ready.
  - In the mem_ready cycle: stall=0; if the line hit at the time of the store, data[idx] is updated at the clock edge (write-through). A store miss does not allocate.
  - Next state IDLE.
- Timing:
  - Miss or store penalty = 1 + memory latency cycles.
  - mem_req and mem_addr are registered-state driven and stay stable until mem_ready.
  - mem_ready while in IDLE is ignored.
- Back-to-back: after the released cycle the core advances the PC. The next request is evaluated in IDLE in the following cycle; no dead cycle is added.
- Aliasing: two addresses with the same index and different tags evict each other on read fill.
- Reset mid-transaction:
  - Immediately returns to IDLE and drops mem_req.
  - Invalidates all lines.
  - A pending memory response is discarded.
  - The memory model must also be reset.
- X-safety: when valid=0 the tag compare result is ignored. ReadData=0 whenever the block is not returning data.

Decomposition:
- Package `dcache_pkg`:
  - typedef enum logic[1:0] {IDLE, RD_WAIT, WR_WAIT} dc_state_t.
  - localparams DC_LINES=64, DC_N_BITS=32.
  - Functions get_index(addr) and get_tag(addr).
- Sub-module `dcache_array`: tag/data/valid storage.
  - Asynchronous read by index.
  - Synchronous fill/update write port.
  - Asynchronous clear of valid bits on rst.
- The top level holds the FSM, the latches and the handshake logic.

Test Plan:
1. Cold read miss:
   - Stimulus: reset, then MemRead Addr=0x0000_0010; memory returns 0xDEAD_BEEF with mem_ready after 3 cycles.
   - Required: stall=1 for 3 cycles; mem_req=1 with mem_addr=0x10, mem_we=0; stall=0 with ReadData=0xDEAD_BEEF in the ready cycle.
2. Read hit:
   - Stimulus: after scenario 1, MemRead Addr=0x10.
   - Required: stall=0, ReadData=0xDEAD_BEEF the same cycle; mem_req stays 0.
3. Store hit, write-through:
   - Stimulus: MemWrite Addr=0x10, WriteData=0x1234_5678, mem_ready after 2 cycles.
   - Required: mem_we=1, mem_wdata=0x1234_5678, stall released on mem_ready; a subsequent read of 0x10 hits with ReadData=0x1234_5678.
4. Store miss, no allocate:
   - Stimulus: MemWrite Addr=0x200 (cold).
   - Required: memory is written; a following read of 0x200 misses (mem_req=1).
5. Conflict eviction (LINES=64):
   - Stimulus: read 0x010, then 0x110, then 0x010.
   - Required: all three miss (same index 4, different tags), each fills from memory.
6. Reset mid-transaction:
   - Stimulus: assert rst during RD_WAIT.
   - Required: mem_req=0 and stall=0 immediately; after deassert, a read of the previously cached 0x10 misses.
